sampling_ctrl_gen: RTL and testbench
====================================

Name: sampling_ctrl_gen

Overview:
Parametrised sample-rate controller and the successor of the fixed five-mode sampling controller. It generates the DDSEnable sample strobe from Fg_CLK using a decade-style divider table of NUM_MODES entries. The mode can be stepped by button pulse or loaded directly. Mode changes apply only at a sample-period boundary, so no period is ever truncated. It sits between the button/interface logic and the DDS phase accumulator, and gates the accumulator through DDSReady after a warm-up delay.

Parameters:
CNT_W, 14, divider counter width
NUM_MODES, 5, number of rate modes (>=2)
DIV_BASE, 10, ratio step between adjacent modes
READY_DLY, 80, warm-up cycles after reset before DDSReady
INIT_MODE, 0, mode loaded at reset (< NUM_MODES)
MODE_W, $clog2(NUM_MODES), mode field width (derived)

Ports:
Fg_CLK  in  1  single clock; all logic on its rising edge
Fg_RESET  in  1  synchronous, active-high reset
oIntBtn  in  1  single-cycle step request (debounced pulse upstream)
ModeLoad  in  1  single-cycle direct mode load strobe
ModeIn  in  MODE_W  mode value for ModeLoad
DDSEnable  out  1  sample strobe
DDSReady  out  1  warm-up complete
DDSMode  out  MODE_W  active mode
ModePending  out  1  change requested, not yet applied
ModeErr  out  1  one-cycle pulse on an out-of-range load

Behaviour:
- Clock and reset: one clock Fg_CLK. Fg_RESET is synchronous and active-high. Reset dominates all other inputs.
- Reset values: DDSEnable=0, DDSReady=0, DDSMode=INIT_MODE, ModePending=0, ModeErr=0, divider count=0, ready count=0, state=WARMUP.
- Terminal count: TC(m) = DIV_BASE^m - 1. DDSEnable period is TC+1 cycles.
- Elaboration check: elaboration fails if DIV_BASE^(NUM_MODES-1)-1 exceeds 2^CNT_W-1.
- WARMUP state:
  - Ready counter increments each cycle.
  - When it reaches READY_DLY-1, DDSReady is registered high on the next edge and the state moves to RUN. DDSReady is therefore high from the READY_DLY-th edge after reset release.
  - DDSEnable is held 0 and the divider is held at 0.
  - Requests are accepted, go straight into DDSMode, and do not set ModePending.
- RUN state:
  - Divider counts 0..TC(DDSMode) and wraps to 0.
  - DDSEnable is a registered pulse: high for the one cycle following the edge where the count equals TC.
  - The first pulse comes TC+1 cycles after DDSReady rises.
  - TC=0 (mode 0): DDSEnable stays continuously high.
- Request handling in RUN:
  - A valid request writes a pending-mode register, sets ModePending and moves to PEND.
  - oIntBtn: pending = active mode + 1, wrapping from NUM_MODES-1 to 0.
  - ModeLoad: pending = ModeIn.
- PEND state:
  - Divider continues under the old TC.
  - On the wrap edge (count==TC), DDSMode takes the pending value, the count restarts at 0 under the new TC, ModePending clears and the state returns to RUN.
  - The strobe for that final old-mode period is still issued.
- Further requests in PEND update pending:
  - oIntBtn steps from the pending value, not from DDSMode.
  - ModeLoad overwrites the pending value.
- Simultaneous ModeLoad and oIntBtn: ModeLoad wins and oIntBtn is dropped.
- Request on the apply edge itself: the apply happens first; the request is then treated as a new pending request against the new DDSMode.
- Out-of-range load (ModeIn >= NUM_MODES):
  - Ignored; no state change.
  - ModeErr pulses high for 1 cycle on the next edge.
  - A simultaneous oIntBtn is also dropped.
- DDSReady, once high, stays high until reset. Mode changes do not drop it.
- Reset mid-operation: on the next edge all registers return to reset values, any pending request is discarded and warm-up restarts.

Decomposition:
- Package sampling_ctrl_pkg holds:
  - state enum: WARMUP, RUN, PEND
  - constant function tc_of(mode, DIV_BASE, CNT_W) returning the terminal count, used to build a NUM_MODES-entry TC lookup
  - elaboration width-check function
- Sub-module rate_divider(CNT_W): programmable terminal-count counter.
  - Inputs: clr, tc.
  - Output: registered tick.
  - Also reports wrap, used by the top level as the apply point.

Test Plan (defaults):
1. Release reset, no requests -> DDSReady low for edges 1..79, high from edge 80. DDSEnable 0 during warm-up, then continuously 1 (mode 0).
2. Load 2 during warm-up; after ready, pulse oIntBtn at divider count 40 -> ModePending=1. DDSMode stays 2 until the count-99 wrap, then becomes 3. Following DDSEnable pulses are 1000 cycles apart; period spacing at the switch is exactly 100 cycles.
3. In mode 4 (TC 9999), pulse oIntBtn -> at the next wrap DDSMode becomes 0 and DDSEnable goes continuously high.
4. ModeLoad with ModeIn=7 -> ModeErr one-cycle pulse, DDSMode and ModePending unchanged. ModeLoad=3 with oIntBtn in the same cycle -> pending 3, not DDSMode+1.
5. In PEND from mode 1 (pending 2), pulse oIntBtn twice -> pending 4. At the wrap, DDSMode jumps 1 -> 4.
6. Assert Fg_RESET for 1 cycle in PEND mode 3 -> next edge: DDSReady=0, DDSEnable=0, DDSMode=0, ModePending=0. DDSReady re-rises 80 edges after release.

Source files
------------

// File: rtl/sampling_ctrl_pkg.sv
// sampling_ctrl_pkg: shared types and elaboration helpers for the
// sample-rate controller (state enum, terminal-count math).
package sampling_ctrl_pkg;

  typedef enum logic [1:0] {
    WARMUP,
    RUN,
    PEND
  } state_t;

  typedef longint unsigned u64_t;

  // DIV_BASE^mode - 1, masked to the counter width.
  function automatic u64_t tc_of(
    input int mode,
    input int divBase,
    input int cntW
  );
    u64_t p;
    p = 1;
    for (int i = 0; i < mode; i++) begin
      p = p * u64_t'(divBase);
    end
    return (p - 1) & ((u64_t'(1) << cntW) - 1);
  endfunction

  // True when the slowest mode's terminal count fits in cntW bits.
  function automatic bit tc_fits(
    input int numModes,
    input int divBase,
    input int cntW
  );
    u64_t p;
    u64_t lim;
    p   = 1;
    lim = u64_t'(1) << cntW;
    for (int i = 0; i < numModes - 1; i++) begin
      p = p * u64_t'(divBase);
      if (p > lim) return 1'b0;
    end
    return (p - 1) <= (lim - 1);
  endfunction

endpackage

// File: rtl/rate_divider.sv
// rate_divider: counts 0..tc and wraps; tick is the registered wrap.
// Ports: Fg_CLK, Fg_RESET, clr (hold at 0), tc, tick, wrap.
module rate_divider #(
  parameter int CNT_W = 14
) (
  input  logic             Fg_CLK,
  input  logic             Fg_RESET,
  input  logic             clr,
  input  logic [CNT_W-1:0] tc,
  output logic             tick,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;

  assign wrap = ~clr & (cnt == tc);

  always_ff @(posedge Fg_CLK) begin
    if (Fg_RESET) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      if (clr | wrap) cnt <= '0;
      else            cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sampling_ctrl_gen.sv
// sampling_ctrl_gen: DDS sample strobe generator with boundary-aligned
// mode changes. Ports: Fg_CLK, Fg_RESET, oIntBtn, ModeLoad, ModeIn,
// DDSEnable, DDSReady, DDSMode, ModePending, ModeErr.
module sampling_ctrl_gen
  import sampling_ctrl_pkg::*;
#(
  parameter int CNT_W     = 14,
  parameter int NUM_MODES = 5,
  parameter int DIV_BASE  = 10,
  parameter int READY_DLY = 80,
  parameter int INIT_MODE = 0,
  parameter int MODE_W    = $clog2(NUM_MODES)
) (
  input  logic              Fg_CLK,
  input  logic              Fg_RESET,
  input  logic              oIntBtn,
  input  logic              ModeLoad,
  input  logic [MODE_W-1:0] ModeIn,
  output logic              DDSEnable,
  output logic              DDSReady,
  output logic [MODE_W-1:0] DDSMode,
  output logic              ModePending,
  output logic              ModeErr
);

  localparam int RDY_W = $clog2(READY_DLY) + 1;

  if (!tc_fits(NUM_MODES, DIV_BASE, CNT_W)) begin : gTcCheck
    $error("sampling_ctrl_gen: slowest TC exceeds CNT_W");
  end
  if (INIT_MODE >= NUM_MODES) begin : gInitCheck
    $error("sampling_ctrl_gen: INIT_MODE out of range");
  end

  logic [CNT_W-1:0] tcLut [NUM_MODES];
  for (genvar g = 0; g < NUM_MODES; g++) begin : gLut
    assign tcLut[g] = CNT_W'(tc_of(g, DIV_BASE, CNT_W));
  end

  state_t            state, stateNxt;
  logic [MODE_W-1:0] modeQ, modeNxt;
  logic [MODE_W-1:0] pendQ, pendNxt;
  logic              pendFlag, pendFlagNxt;
  logic              errQ, errNxt;
  logic              readyQ, readyNxt;
  logic [RDY_W-1:0]  rdyCnt, rdyCntNxt;

  logic inRange;
  logic loadOk;
  logic btnReq;
  logic wrap;
  logic tick;

  function automatic logic [MODE_W-1:0] stepMode(
    input logic [MODE_W-1:0] m
  );
    if (m == MODE_W'(NUM_MODES - 1)) return '0;
    return m + 1'b1;
  endfunction

  assign inRange = {1'b0, ModeIn} < (MODE_W + 1)'(NUM_MODES);
  assign loadOk  = ModeLoad & inRange;
  // A load strobe, good or bad, always swallows a same-cycle button.
  assign btnReq  = oIntBtn & ~ModeLoad;

  rate_divider #(
    .CNT_W (CNT_W)
  ) uDiv (
    .Fg_CLK   (Fg_CLK),
    .Fg_RESET (Fg_RESET),
    .clr      (state == WARMUP),
    .tc       (tcLut[modeQ]),
    .tick     (tick),
    .wrap     (wrap)
  );

  always_comb begin
    stateNxt    = state;
    modeNxt     = modeQ;
    pendNxt     = pendQ;
    pendFlagNxt = pendFlag;
    errNxt      = ModeLoad & ~inRange;
    readyNxt    = readyQ;
    rdyCntNxt   = rdyCnt;
    unique case (state)
      WARMUP: begin
        rdyCntNxt = rdyCnt + 1'b1;
        if (loadOk)      modeNxt = ModeIn;
        else if (btnReq) modeNxt = stepMode(modeQ);
        if (rdyCnt == RDY_W'(READY_DLY - 1)) begin
          readyNxt = 1'b1;
          stateNxt = RUN;
        end
      end
      RUN: begin
        if (loadOk | btnReq) begin
          pendNxt     = loadOk ? ModeIn : stepMode(modeQ);
          pendFlagNxt = 1'b1;
          stateNxt    = PEND;
        end
      end
      PEND: begin
        if (wrap) begin
          modeNxt     = pendQ;
          pendFlagNxt = 1'b0;
          stateNxt    = RUN;
        end
        // Stepping from pendQ equals stepping from the just-applied mode.
        if (loadOk | btnReq) begin
          pendNxt     = loadOk ? ModeIn : stepMode(pendQ);
          pendFlagNxt = 1'b1;
          stateNxt    = PEND;
        end
      end
      default: stateNxt = WARMUP;
    endcase
  end

  always_ff @(posedge Fg_CLK) begin
    if (Fg_RESET) begin
      state    <= WARMUP;
      modeQ    <= MODE_W'(INIT_MODE);
      pendQ    <= '0;
      pendFlag <= 1'b0;
      errQ     <= 1'b0;
      readyQ   <= 1'b0;
      rdyCnt   <= '0;
    end else begin
      state    <= stateNxt;
      modeQ    <= modeNxt;
      pendQ    <= pendNxt;
      pendFlag <= pendFlagNxt;
      errQ     <= errNxt;
      readyQ   <= readyNxt;
      rdyCnt   <= rdyCntNxt;
    end
  end

  assign DDSEnable   = tick;
  assign DDSReady    = readyQ;
  assign DDSMode     = modeQ;
  assign ModePending = pendFlag;
  assign ModeErr     = errQ;

endmodule

// File: tb/tb_sampling_ctrl_gen.sv
// tb_sampling_ctrl_gen: scoreboard bench for sampling_ctrl_gen with an
// event-time reference model and directed plus random stimulus.
module tb_sampling_ctrl_gen;

  localparam int NM = 5;
  localparam int MW = 3;
  localparam int RD = 80;
  localparam int DB = 10;

  logic          Fg_CLK = 1'b0;
  logic          Fg_RESET = 1'b1;
  logic          oIntBtn = 1'b0;
  logic          ModeLoad = 1'b0;
  logic [MW-1:0] ModeIn = '0;
  logic          DDSEnable;
  logic          DDSReady;
  logic [MW-1:0] DDSMode;
  logic          ModePending;
  logic          ModeErr;

  typedef struct packed {
    logic          en;
    logic          rdy;
    logic [MW-1:0] mode;
    logic          pend;
    logic          err;
  } obs_t;

  obs_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  sampling_ctrl_gen #(
    .CNT_W     (14),
    .NUM_MODES (NM),
    .DIV_BASE  (DB),
    .READY_DLY (RD),
    .INIT_MODE (0)
  ) dut (
    .Fg_CLK      (Fg_CLK),
    .Fg_RESET    (Fg_RESET),
    .oIntBtn     (oIntBtn),
    .ModeLoad    (ModeLoad),
    .ModeIn      (ModeIn),
    .DDSEnable   (DDSEnable),
    .DDSReady    (DDSReady),
    .DDSMode     (DDSMode),
    .ModePending (ModePending),
    .ModeErr     (ModeErr)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  function automatic int period(input int m);
    int p;
    p = 1;
    for (int i = 0; i < m; i++) p = p * DB;
    return p;
  endfunction

  // Reference: tracks the edge number of the next strobe, not a counter.
  initial begin : model
    int   since;
    int   mode;
    int   pend;
    int   nextWrap;
    int   req;
    bit   en;
    bit   err;
    obs_t e;
    since = 0;
    mode = 0;
    pend = -1;
    nextWrap = 0;
    forever begin
      @(posedge Fg_CLK);
      cyc++;
      en = 1'b0;
      err = 1'b0;
      req = -1;
      if (Fg_RESET) begin
        since = 0;
        mode = 0;
        pend = -1;
      end else begin
        since++;
        err = ModeLoad && (int'(ModeIn) >= NM);
        if (ModeLoad && !err) req = int'(ModeIn);
        else if (oIntBtn && !ModeLoad) req = -2;
        if (since <= RD) begin
          if (req == -2) mode = (mode + 1) % NM;
          else if (req >= 0) mode = req;
          if (since == RD) nextWrap = since + period(mode);
        end else begin
          en = (since == nextWrap);
          if (en) begin
            if (pend >= 0) begin
              mode = pend;
              pend = -1;
            end
            nextWrap = since + period(mode);
          end
          if (req == -2) pend = ((pend >= 0 ? pend : mode) + 1) % NM;
          else if (req >= 0) pend = req;
        end
      end
      e.en   = en;
      e.rdy  = (since >= RD);
      e.mode = MW'(mode);
      e.pend = (pend >= 0);
      e.err  = err;
      expQ.push_back(e);
    end
  end

  initial begin : monitor
    obs_t e;
    obs_t g;
    forever begin
      @(negedge Fg_CLK);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        g.en   = DDSEnable;
        g.rdy  = DDSReady;
        g.mode = DDSMode;
        g.pend = ModePending;
        g.err  = ModeErr;
        checks++;
        if (g !== e) begin
          failures++;
          if (failures <= 20)
            $display("FAIL outputs cycle=%0d got en=%b rdy=%b mode=%0d pend=%b err=%b want en=%b rdy=%b mode=%0d pend=%b err=%b",
                     cyc, g.en, g.rdy, g.mode, g.pend, g.err,
                     e.en, e.rdy, e.mode, e.pend, e.err);
        end
      end
    end
  end

  task automatic drive(input bit r, input bit b, input bit l, input int m);
    @(negedge Fg_CLK);
    Fg_RESET = r;
    oIntBtn  = b;
    ModeLoad = l;
    ModeIn   = MW'(m);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  initial begin : stim
    int r;
    repeat (3) drive(1, 0, 0, 0);
    idle(200);
    drive(1, 0, 0, 0);
    idle(10);
    drive(0, 0, 1, 2);
    idle(RD + 30);
    drive(0, 1, 0, 0);
    idle(3200);
    drive(0, 1, 1, 7);
    idle(5);
    drive(0, 1, 1, 3);
    idle(1100);
    drive(0, 0, 1, 1);
    idle(1100);
    drive(0, 0, 1, 2);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    idle(40);
    drive(0, 1, 0, 0);
    idle(10100);
    idle(20);
    drive(0, 0, 1, 3);
    idle(10);
    drive(0, 1, 0, 0);
    idle(20);
    drive(1, 0, 0, 0);
    idle(200);
    for (int i = 0; i < 30000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3)       drive(0, 1, 0, 0);
      else if (r < 6)  drive(0, 0, 1, $urandom_range(0, 7));
      else if (r < 7)  drive(0, 1, 1, $urandom_range(0, 7));
      else if (r == 7 && $urandom_range(0, 19) == 0) drive(1, 0, 0, 0);
      else             drive(0, 0, 0, 0);
    end
    idle(2);
    repeat (2) @(posedge Fg_CLK);
    #7;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d left want=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
